bitslip_align_ctrl: RTL and testbench
=====================================

BITSLIP_ALIGN_CTRL -- requirements
Module: bitslip_align_ctrl

Interface
REQ-001 SHALL have parameter PATTERN, default 12'hFC0, 12-bit training word expected on Q when aligned.
REQ-002 SHALL have parameter RST_CYC, default 8, cycles SERDES_RST is held high.
REQ-003 SHALL have parameter SETTLE_CYC, default 4, wait cycles after any SERDES reset or bitslip before Q is compared.
REQ-004 SHALL have parameter LOCK_CNT, default 8, consecutive matches required to declare lock.
REQ-005 SHALL have parameter MAX_SLIP, default 6, bitslip positions available (6-bit SDR width per deserializer).
REQ-006 SHALL have parameter LOSS_CNT, default 4, consecutive mismatches in LOCKED that force retraining.
REQ-007 SHALL have port CLKDIV, input, 1 bit: the only clock (divided deserializer clock); all logic on rising edge.
REQ-008 SHALL have port RSTN, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port START, input, 1 bit: training request, sampled each cycle.
REQ-010 SHALL have port Q, input, 12 bits: parallel word from the 1x12 DDR deserializer.
REQ-011 SHALL have port SERDES_RST, output, 1 bit: active-high reset to both deserializers.
REQ-012 SHALL have port BITSLIP, output, 1 bit: single-cycle slip pulse to both deserializers.
REQ-013 SHALL have port BUSY, output, 1 bit: high in RESET_SERDES, SETTLE, CHECK and SLIP.
REQ-014 SHALL have port LOCKED, output, 1 bit: high only in state LOCKED.
REQ-015 SHALL have port FAIL, output, 1 bit: high only in state FAIL.
REQ-016 SHALL have port SLIP_CNT, output, 3 bits: number of slips issued since the last SERDES reset.

Function
REQ-017 SHALL implement states IDLE, RESET_SERDES, SETTLE, CHECK, SLIP, LOCKED, FAIL, with all outputs registered.
REQ-018 IDLE: START=1 -> RESET_SERDES next cycle; otherwise remain in IDLE.
REQ-019 RESET_SERDES: SERDES_RST=1 for exactly RST_CYC cycles, SLIP_CNT cleared to 0, then SETTLE.
REQ-020 SETTLE: count SETTLE_CYC cycles with Q ignored, clear the match counter, then CHECK.
REQ-021 CHECK: Q==PATTERN increments the match counter; on reaching LOCK_CNT, go to LOCKED next cycle.
REQ-022 CHECK: Q!=PATTERN with SLIP_CNT<MAX_SLIP-1 -> SLIP; with SLIP_CNT==MAX_SLIP-1 -> FAIL (all positions tried).
REQ-023 SLIP: BITSLIP=1 for exactly one cycle, SLIP_CNT increments by 1, then SETTLE; BITSLIP never asserts in any other state.
REQ-024 LOCKED: consecutive-mismatch counter increments on Q!=PATTERN and clears on a match; on reaching LOSS_CNT, LOCKED drops next cycle and the FSM enters RESET_SERDES.
REQ-025 START is ignored while BUSY=1; START=1 in LOCKED or FAIL -> RESET_SERDES (full retrain).
REQ-026 LOCK latency from CHECK entry with a continuously matching Q SHALL be LOCK_CNT cycles.
REQ-027 SLIP_CNT SHALL hold its value in LOCKED and FAIL to report the alignment found.
REQ-028 Counters SHALL saturate at terminal value and never wrap.

Reset
REQ-029 RSTN=0 SHALL asynchronously force IDLE, SERDES_RST=0, BITSLIP=0, BUSY=0, LOCKED=0, FAIL=0, SLIP_CNT=0 and all internal counters to 0.
REQ-030 RSTN deasserting mid-training SHALL resume from IDLE; no BITSLIP or SERDES_RST pulse is generated by the reset itself.

Verification
REQ-031 Q=12'hFC0 from reset, START pulse -> SERDES_RST high 8 cycles, 4 settle cycles, LOCKED=1 after 8 matches, SLIP_CNT=0, no BITSLIP.
REQ-032 Q model rotates PATTERN by 3 positions, rotating one step back per BITSLIP -> exactly 3 BITSLIP pulses, each followed by 4 settle cycles; LOCKED=1 with SLIP_CNT=3.
REQ-033 Q constant 12'h000 -> 5 BITSLIP pulses, then FAIL=1, LOCKED=0, SLIP_CNT=5, BUSY=0.
REQ-034 In LOCKED, inject 3 mismatches then 1 match then 4 mismatches -> LOCKED stays high through the first burst and drops after the 4th consecutive mismatch; SERDES_RST reasserts.
REQ-035 START held high throughout training -> single training sequence; RSTN=0 during SLIP -> BITSLIP=0 and IDLE immediately.
REQ-036 START in FAIL with Q corrected to 12'hFC0 -> retrain from RESET_SERDES; FAIL clears, LOCKED=1 with SLIP_CNT=0.

Source files
------------

// File: rtl/bitslip_align_ctrl.sv
// rtl/bitslip_align_ctrl.sv - word-alignment controller driving SERDES reset and bitslip for a 1x12 DDR deserializer pair
//
// Purpose:
//   Resets the deserializers and waits for them to settle. It then compares
//   the parallel word Q with the training PATTERN. On a mismatch it slips one
//   position and retries. Lock is declared after LOCK_CNT consecutive matches.
//   Once locked, Q is monitored, and LOSS_CNT consecutive mismatches start a
//   full retrain. When every slip position has been tried, the controller
//   parks in FAIL until START is asserted again.
//
// Ports:
//   CLKDIV      in   divided deserializer clock; all logic on the rising edge
//   RSTN        in   asynchronous active-low reset
//   START       in   training request; ignored while BUSY
//   Q[11:0]     in   parallel word from the deserializer
//   SERDES_RST  out  active-high reset to both deserializers
//   BITSLIP     out  single-cycle slip pulse to both deserializers
//   BUSY        out  training in progress
//   LOCKED      out  alignment found and holding
//   FAIL        out  no slip position produced the pattern
//   SLIP_CNT    out  slips issued since the last deserializer reset
module bitslip_align_ctrl #(
  parameter logic [11:0] PATTERN    = 12'hFC0,
  parameter int          RST_CYC    = 8,
  parameter int          SETTLE_CYC = 4,
  parameter int          LOCK_CNT   = 8,
  parameter int          MAX_SLIP   = 6,
  parameter int          LOSS_CNT   = 4
) (
  input  logic        CLKDIV,
  input  logic        RSTN,
  input  logic        START,
  input  logic [11:0] Q,
  output logic        SERDES_RST,
  output logic        BITSLIP,
  output logic        BUSY,
  output logic        LOCKED,
  output logic        FAIL,
  output logic [2:0]  SLIP_CNT
);

  localparam int CW = 8;

  // Terminal values as "last index" so each phase lasts exactly N cycles
  // counting from a zeroed counter on entry.
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] LOCK_TERM   = CW'(LOCK_CNT);
  localparam logic [CW-1:0] LOSS_LAST   = CW'(LOSS_CNT - 1);
  localparam logic [CW-1:0] LOSS_TERM   = CW'(LOSS_CNT);
  localparam logic [2:0]    SLIP_LAST   = 3'(MAX_SLIP - 1);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RESET_SERDES = 3'd1,
    ST_SETTLE       = 3'd2,
    ST_CHECK        = 3'd3,
    ST_SLIP         = 3'd4,
    ST_LOCKED       = 3'd5,
    ST_FAIL         = 3'd6
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] phase_cnt;
  logic [CW-1:0] phase_d;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] match_d;
  logic [CW-1:0] miss_cnt;
  logic [CW-1:0] miss_d;
  logic [2:0]    slip_d;
  logic          q_match;
  logic          serdes_rst_d;
  logic          bitslip_d;
  logic          busy_d;
  logic          locked_d;
  logic          fail_d;

  assign q_match = (Q == PATTERN);

  // State, counters and outputs all update together. The outputs are decoded
  // from the next state, so each one is a flop that agrees with the state
  // register on every cycle.
  always_ff @(posedge CLKDIV or negedge RSTN) begin
    if (!RSTN) begin
      state      <= ST_IDLE;
      phase_cnt  <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      SLIP_CNT   <= 3'd0;
      SERDES_RST <= 1'b0;
      BITSLIP    <= 1'b0;
      BUSY       <= 1'b0;
      LOCKED     <= 1'b0;
      FAIL       <= 1'b0;
    end else begin
      state      <= state_d;
      phase_cnt  <= phase_d;
      match_cnt  <= match_d;
      miss_cnt   <= miss_d;
      SLIP_CNT   <= slip_d;
      SERDES_RST <= serdes_rst_d;
      BITSLIP    <= bitslip_d;
      BUSY       <= busy_d;
      LOCKED     <= locked_d;
      FAIL       <= fail_d;
    end
  end

  always_comb begin
    state_d = state;
    phase_d = phase_cnt;
    match_d = match_cnt;
    miss_d  = miss_cnt;
    slip_d  = SLIP_CNT;

    case (state)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RESET_SERDES;
          phase_d = '0;
          slip_d  = 3'd0;
        end
      end

      ST_RESET_SERDES: begin
        if (phase_cnt >= RST_LAST) begin
          state_d = ST_SETTLE;
          phase_d = '0;
          match_d = '0;
        end else begin
          phase_d = phase_cnt + CW'(1);
        end
      end

      // Q is still moving after a reset or slip, so it is not looked at here.
      ST_SETTLE: begin
        match_d = '0;
        if (phase_cnt >= SETTLE_LAST) begin
          state_d = ST_CHECK;
          phase_d = '0;
        end else begin
          phase_d = phase_cnt + CW'(1);
        end
      end

      // A single mismatch abandons this slip position. The matches needed
      // for lock must all be consecutive.
      ST_CHECK: begin
        if (q_match) begin
          if (match_cnt >= LOCK_LAST) begin
            state_d = ST_LOCKED;
            match_d = LOCK_TERM;
            miss_d  = '0;
          end else begin
            match_d = match_cnt + CW'(1);
          end
        end else if (SLIP_CNT >= SLIP_LAST) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_SLIP;
          if (SLIP_CNT != 3'd7) begin
            slip_d = SLIP_CNT + 3'd1;
          end
        end
      end

      ST_SLIP: begin
        state_d = ST_SETTLE;
        phase_d = '0;
      end

      // START takes priority over loss monitoring. A retrain started either
      // way goes back through the deserializer reset.
      ST_LOCKED: begin
        if (START) begin
          state_d = ST_RESET_SERDES;
          phase_d = '0;
          slip_d  = 3'd0;
        end else if (!q_match) begin
          if (miss_cnt >= LOSS_LAST) begin
            state_d = ST_RESET_SERDES;
            phase_d = '0;
            slip_d  = 3'd0;
            miss_d  = LOSS_TERM;
          end else begin
            miss_d = miss_cnt + CW'(1);
          end
        end else begin
          miss_d = '0;
        end
      end

      ST_FAIL: begin
        if (START) begin
          state_d = ST_RESET_SERDES;
          phase_d = '0;
          slip_d  = 3'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        match_d = '0;
        miss_d  = '0;
        slip_d  = 3'd0;
      end
    endcase

    serdes_rst_d = (state_d == ST_RESET_SERDES);
    bitslip_d    = (state_d == ST_SLIP);
    busy_d       = (state_d == ST_RESET_SERDES) || (state_d == ST_SETTLE) ||
                   (state_d == ST_CHECK) || (state_d == ST_SLIP);
    locked_d     = (state_d == ST_LOCKED);
    fail_d       = (state_d == ST_FAIL);
  end

endmodule

// File: tb/tb_bitslip_align_ctrl.sv
// tb/tb_bitslip_align_ctrl.sv - self-checking bench for bitslip_align_ctrl
module tb_bitslip_align_ctrl;
  localparam logic [11:0] PATTERN    = 12'hFC0;
  localparam int          RST_CYC    = 8;
  localparam int          SETTLE_CYC = 4;
  localparam int          LOCK_CNT   = 8;
  localparam int          MAX_SLIP   = 6;
  localparam int          LOSS_CNT   = 4;

  logic        CLKDIV = 1'b0;
  logic        RSTN   = 1'b0;
  logic        START  = 1'b0;
  logic [11:0] Q      = PATTERN;
  logic        SERDES_RST;
  logic        BITSLIP;
  logic        BUSY;
  logic        LOCKED;
  logic        FAIL;
  logic [2:0]  SLIP_CNT;

  int tests = 0;
  int fails = 0;

  always #5 CLKDIV = ~CLKDIV;

  bitslip_align_ctrl #(
    .PATTERN(PATTERN), .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC),
    .LOCK_CNT(LOCK_CNT), .MAX_SLIP(MAX_SLIP), .LOSS_CNT(LOSS_CNT)
  ) dut (
    .CLKDIV(CLKDIV), .RSTN(RSTN), .START(START), .Q(Q),
    .SERDES_RST(SERDES_RST), .BITSLIP(BITSLIP), .BUSY(BUSY),
    .LOCKED(LOCKED), .FAIL(FAIL), .SLIP_CNT(SLIP_CNT)
  );

  // Expected per-cycle output words: {rst, bitslip, busy, locked, fail, slip_cnt[2:0]}
  logic [7:0]  exp_q[$];
  logic [11:0] inj_q[$];
  int          inj_start = -1;

  // Deserializer model: the word arrives rotated by env_k positions and each
  // slip rotates it one step back; a deserializer reset restores env_k.
  int env_k       = 0;
  bit env_garbage = 1'b0;
  int env_slips   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [11:0] rotl(input logic [11:0] v, input int r);
    logic [11:0] x;
    x = v;
    for (int i = 0; i < r; i++) x = {x[10:0], x[11]};
    return x;
  endfunction

  function automatic logic [11:0] q_model();
    if (env_garbage) return 12'h000;
    return rotl(PATTERN, ((env_k - env_slips) % 12 + 12) % 12);
  endfunction

  function automatic logic [7:0] enc(input bit rst, input bit bs, input bit busy,
                                     input bit lk, input bit fl, input int sc);
    logic [2:0] s;
    s = 3'(sc);
    return {rst, bs, busy, lk, fl, s};
  endfunction

  function automatic logic [7:0] obs();
    return {SERDES_RST, BITSLIP, BUSY, LOCKED, FAIL, SLIP_CNT};
  endfunction

  task automatic push_n(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Expected outputs of one training run from the first cycle after START is
  // taken: reset, then for each slip position a settle window and a check,
  // ending in a lock (pattern present) or in FAIL once every position is used.
  task automatic add_train(input int k, input bit garbage, input int hold);
    int s;
    s = 0;
    push_n(enc(1, 0, 1, 0, 0, 0), RST_CYC);
    forever begin
      push_n(enc(0, 0, 1, 0, 0, s), SETTLE_CYC);
      if (!garbage && (s == k)) begin
        push_n(enc(0, 0, 1, 0, 0, s), LOCK_CNT);
        push_n(enc(0, 0, 0, 1, 0, s), hold);
        break;
      end
      push_n(enc(0, 0, 1, 0, 0, s), 1);
      if (s < MAX_SLIP - 1) begin
        s++;
        push_n(enc(0, 1, 1, 0, 0, s), 1);
      end else begin
        push_n(enc(0, 0, 0, 0, 1, s), hold);
        break;
      end
    end
  endtask

  task automatic kick(input int k, input bit garbage);
    @(negedge CLKDIV);
    env_k       = k;
    env_garbage = garbage;
    env_slips   = 0;
    Q           = q_model();
    START       = 1'b1;
  endtask

  task automatic run_trace(input string tag, input bit hold_start, input bit abort_on_slip);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge CLKDIV);
      check($sformatf("%s[%0d]", tag, i), 32'(obs()), 32'(exp_q[i]));
      if (abort_on_slip && exp_q[i][6]) begin
        RSTN = 1'b0;
        #1;
        check({tag, "_async_rst"}, 32'(obs()), 32'h0);
        @(negedge CLKDIV);
        check({tag, "_in_rst"}, 32'(obs()), 32'h0);
        RSTN = 1'b1;
        for (int j = 0; j < 4; j++) begin
          @(negedge CLKDIV);
          check($sformatf("%s_idle[%0d]", tag, j), 32'(obs()), 32'h0);
        end
        exp_q.delete();
        inj_start = -1;
        return;
      end
      if (BITSLIP) env_slips++;
      if (SERDES_RST) env_slips = 0;
      if (!hold_start || !exp_q[i][5]) START = 1'b0;
      if (inj_start >= 0 && i >= inj_start && (i - inj_start) < inj_q.size())
        Q = inj_q[i - inj_start];
      else
        Q = q_model();
    end
    exp_q.delete();
    inj_start = -1;
  endtask

  // Lock, then drive a mismatch/match sequence; lock is lost at the first
  // point where LOSS_CNT mismatches have been seen back to back.
  task automatic loss_scn(input string tag, input int k, input bit fixed);
    bit miss[$];
    int run;
    int n;
    logic [11:0] bad;
    if (fixed) begin
      miss = '{1, 1, 1, 0, 1, 1, 1, 1};
    end else begin
      for (int j = 0; j < 10; j++) miss.push_back($urandom_range(0, 9) < 6);
      for (int j = 0; j < LOSS_CNT; j++) miss.push_back(1'b1);
    end
    run = 0;
    n   = miss.size();
    for (int j = 0; j < miss.size(); j++) begin
      run = miss[j] ? run + 1 : 0;
      if (run == LOSS_CNT) begin
        n = j + 1;
        break;
      end
    end
    kick(k, 1'b0);
    add_train(k, 1'b0, 3);
    inj_start = exp_q.size() - 1;
    for (int j = 0; j < n; j++) begin
      bad = 12'($urandom_range(1, 4095));
      inj_q.push_back(miss[j] ? (PATTERN ^ bad) : PATTERN);
    end
    push_n(enc(0, 0, 0, 1, 0, k), n - 1);
    add_train(k, 1'b0, 3);
    run_trace(tag, 1'b0, 1'b0);
    inj_q.delete();
  endtask

  initial begin
    int k;
    bit g;
    bit hs;

    repeat (2) @(negedge CLKDIV);
    check("reset_outputs", 32'(obs()), 32'h0);
    RSTN = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge CLKDIV);
      check($sformatf("idle[%0d]", j), 32'(obs()), 32'h0);
    end

    kick(0, 1'b0);
    add_train(0, 1'b0, 4);
    run_trace("aligned", 1'b0, 1'b0);

    kick(3, 1'b0);
    add_train(3, 1'b0, 4);
    run_trace("rot3", 1'b0, 1'b0);

    kick(0, 1'b1);
    add_train(0, 1'b1, 4);
    run_trace("all_zero", 1'b0, 1'b0);

    kick(0, 1'b0);
    add_train(0, 1'b0, 4);
    run_trace("fail_retrain", 1'b0, 1'b0);

    loss_scn("loss_fixed", 2, 1'b1);

    kick(4, 1'b0);
    add_train(4, 1'b0, 4);
    run_trace("start_held", 1'b1, 1'b0);

    kick(2, 1'b0);
    add_train(2, 1'b0, 3);
    run_trace("rst_in_slip", 1'b0, 1'b1);

    for (int it = 0; it < 8; it++) begin
      k  = $urandom_range(0, 11);
      g  = ($urandom_range(0, 4) == 0);
      hs = $urandom_range(0, 1);
      repeat ($urandom_range(0, 5)) @(negedge CLKDIV);
      if (!g && k < MAX_SLIP && $urandom_range(0, 1) == 1) begin
        loss_scn($sformatf("rnd_loss%0d", it), k, 1'b0);
      end else begin
        kick(k, g);
        add_train(k, g, 3);
        run_trace($sformatf("rnd%0d_k%0d", it, k), hs, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
